ram_read_arbiter: RTL and testbench

- Shares one synchronous single-port value/index RAM read port between NUM_REQ ram_fifo-style readers (e.g. weight stream and activation stream).
- Grants are round-robin with bounded bursts. An owner may hold the port for up to MAX_BURST consecutive beats, then it must yield to any other requester.
- Read data returns one cycle after grant. It is broadcast on shared buses and qualified by a per-requester rvalid.

---
 rtl/bitfuscnn_pkg.sv | 39 +++
 rtl/ram_read_arbiter_rr_pick.sv | 41 ++++
 rtl/ram_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_read_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bitfuscnn_pkg.sv
// Shared definitions for the bitfuscnn RAM-side arbiters: default RAM word
// widths and a round-robin search helper used by the priority pickers.
package bitfuscnn_pkg;

  localparam int DEFAULT_RAM_ADDRESS_WIDTH = 14;
  localparam int DEFAULT_RAM_VALUE_WIDTH   = 32;
  localparam int DEFAULT_RAM_INDEX_WIDTH   = 64;

  // Widest requester vector the round-robin helper can search.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_MAX_IDX_W = 5;

  // First set bit of mask at or after start, wrapping modulo n.
  // Returns start when no bit in mask[n-1:0] is set; callers qualify the
  // result with |mask.
  function automatic int unsigned rr_next(
    input logic [RR_MAX_REQ-1:0] mask,
    input int unsigned start,
    input int unsigned n
  );
    int unsigned result;
    int unsigned k;
    logic found;
    result = start;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      k = start + i;
      if (k >= n) begin
        k = k - n;
      end
      if ((i < n) && !found && mask[k[RR_MAX_IDX_W-1:0]]) begin
        found = 1'b1;
        result = k;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker. Given a request vector
// and a start index it returns the first requester at or after start (with
// wrap-around) as both a one-hot grant and a binary index.
module rr_pick
  import bitfuscnn_pkg::*;
#(
  parameter int N = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [RR_MAX_REQ-1:0] mask_wide;
  int unsigned pick;

  // Zero-extend the request vector to the helper's fixed search width.
  always_comb begin
    mask_wide = '0;
    mask_wide[N-1:0] = req;
  end

  // Search order starts at start and wraps through all N requesters.
  always_comb begin
    pick = rr_next(mask_wide, int'(start), N);
  end

  assign idx = IDX_W'(pick);
  assign any = |req;

  // One-hot decode of the picked index, suppressed when nobody requests.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one synchronous single-port value/index RAM read
// port between NUM_REQ streaming readers. Round-robin with bounded bursts:
// an owner keeps the port for at most MAX_BURST consecutive beats while it
// keeps requesting. Read data is broadcast and qualified by a one-hot rvalid
// that trails the grant by exactly one cycle.
// Optional build macro RAM_READ_ARBITER_PERF_EN adds per-requester
// grant/wait performance counters (16-bit, saturating).
module ram_read_arbiter
  import bitfuscnn_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int RAM_ADDRESS_WIDTH = DEFAULT_RAM_ADDRESS_WIDTH,
  parameter int RAM_VALUE_WIDTH   = DEFAULT_RAM_VALUE_WIDTH,
  parameter int RAM_INDEX_WIDTH   = DEFAULT_RAM_INDEX_WIDTH,
  parameter int MAX_BURST         = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*RAM_ADDRESS_WIDTH-1:0] req_address,
  output logic [NUM_REQ-1:0]                   grant,
  output logic [RAM_ADDRESS_WIDTH-1:0]         ram_address,
  output logic                                 ram_en,
  input  logic [RAM_VALUE_WIDTH-1:0]           ram_value,
  input  logic [RAM_INDEX_WIDTH-1:0]           ram_indices_value,
  output logic [RAM_VALUE_WIDTH-1:0]           value_out,
  output logic [RAM_INDEX_WIDTH-1:0]           indices_out,
`ifdef RAM_READ_ARBITER_PERF_EN
  output logic [NUM_REQ*16-1:0]                grant_count,
  output logic [NUM_REQ*16-1:0]                wait_count,
`endif
  output logic [NUM_REQ-1:0]                   rvalid
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   owner_reg;
  logic               owner_valid_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [NUM_REQ-1:0] rvalid_reg;

  logic [IDX_W-1:0]   start_idx;
  logic               keep_owner;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  // Round-robin search begins just after the last owner, so the owner
  // itself is considered last; this is what re-grants a lone owner whose
  // burst has run out.
  assign start_idx = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

  // The current owner continues while it still requests and has burst left.
  assign keep_owner = owner_valid_reg && req[owner_reg] && (burst_cnt_reg < BURST_LIMIT);

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .start (start_idx),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Same-cycle grant and RAM address; everything is forced idle in reset.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    ram_en      = 1'b0;
    ram_address = '0;
    if (!reset) begin
      if (keep_owner) begin
        grant[owner_reg] = 1'b1;
        grant_idx        = owner_reg;
        grant_any        = 1'b1;
      end else if (pick_any) begin
        grant     = pick_grant;
        grant_idx = pick_idx;
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      ram_en      = 1'b1;
      ram_address = req_address[grant_idx*RAM_ADDRESS_WIDTH +: RAM_ADDRESS_WIDTH];
    end
  end

  // Ownership, burst accounting and the one-cycle rvalid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg       <= LAST_IDX;
      owner_valid_reg <= 1'b0;
      burst_cnt_reg   <= '0;
      rvalid_reg      <= '0;
    end else begin
      rvalid_reg <= grant;
      if (grant_any) begin
        if (keep_owner) begin
          // keep_owner implies burst_cnt_reg < BURST_LIMIT, so no overflow.
          burst_cnt_reg <= burst_cnt_reg + 1'b1;
        end else begin
          owner_reg       <= grant_idx;
          owner_valid_reg <= 1'b1;
          burst_cnt_reg   <= BURST_W'(1);
        end
      end else begin
        // Owner is remembered so round-robin resumes after it.
        owner_valid_reg <= 1'b0;
      end
    end
  end

  assign rvalid      = rvalid_reg;
  assign value_out   = ram_value;
  assign indices_out = ram_indices_value;

`ifdef RAM_READ_ARBITER_PERF_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      logic [15:0] grant_cnt_reg;
      logic [15:0] wait_cnt_reg;

      // Saturating per-requester counts of granted beats and stalled cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          grant_cnt_reg <= '0;
          wait_cnt_reg  <= '0;
        end else begin
          if (grant[gi] && (grant_cnt_reg != 16'hFFFF)) begin
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
          end
          if (req[gi] && !grant[gi] && (wait_cnt_reg != 16'hFFFF)) begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
      end

      assign grant_count[gi*16 +: 16] = grant_cnt_reg;
      assign wait_count[gi*16 +: 16]  = wait_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Testbench for ram_read_arbiter (default parameters, two requesters).
// Directed vectors with literal expected grants, plus a per-cycle
// behavioural model of the round-robin/burst rules checked on every negedge.
module tb_ram_read_arbiter;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int VW = 32;
  localparam int XW = 64;
  localparam int MB = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_address;
  logic [N-1:0]    grant;
  logic [AW-1:0]   ram_address;
  logic            ram_en;
  logic [VW-1:0]   ram_value;
  logic [XW-1:0]   ram_indices_value;
  logic [VW-1:0]   value_out;
  logic [XW-1:0]   indices_out;
  logic [N-1:0]    rvalid;
`ifdef RAM_READ_ARBITER_PERF_EN
  logic [N*16-1:0] grant_count;
  logic [N*16-1:0] wait_count;
`endif

  int total = 0;
  int bad   = 0;

  ram_read_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_address       (req_address),
    .grant             (grant),
    .ram_address       (ram_address),
    .ram_en            (ram_en),
    .ram_value         (ram_value),
    .ram_indices_value (ram_indices_value),
    .value_out         (value_out),
    .indices_out       (indices_out),
`ifdef RAM_READ_ARBITER_PERF_EN
    .grant_count       (grant_count),
    .wait_count        (wait_count),
`endif
    .rvalid            (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address.
  function automatic logic [VW-1:0] vf(input logic [AW-1:0] a);
    return {a, 2'b10, ~a, 2'b01};
  endfunction

  function automatic logic [XW-1:0] xf(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    v = vf(a);
    return {v ^ 32'h5A5A_0F0F, ~v};
  endfunction

  // Synchronous RAM: data one cycle after a read enable.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_value         <= vf(ram_address);
      ram_indices_value <= xf(ram_address);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_owner = N - 1;
  bit            m_live  = 0;
  int            m_beats = 0;
  bit            m_init  = 0;
  logic [N-1:0]  m_rv    = '0;
  logic [AW-1:0] m_addr_prev = '0;

  always @(negedge clk) begin
    int gidx;
    logic [N-1:0]  exp_g;
    logic [AW-1:0] exp_addr;
    gidx = -1;
    if (!reset) begin
      if (m_live && req[m_owner] && m_beats < MB) begin
        gidx = m_owner;
      end else begin
        for (int o = 1; o <= N; o++) begin
          int c;
          c = (m_owner + o) % N;
          if (gidx < 0 && req[c]) gidx = c;
        end
      end
    end
    exp_g    = '0;
    exp_addr = '0;
    if (gidx >= 0) begin
      exp_g[gidx] = 1'b1;
      exp_addr    = req_address[gidx*AW +: AW];
    end
    check("model_grant", 64'(grant), 64'(exp_g));
    check("model_ram_en", 64'(ram_en), 64'(gidx >= 0));
    check("model_ram_address", 64'(ram_address), 64'(exp_addr));
    if (m_init) begin
      check("model_rvalid", 64'(rvalid), 64'(m_rv));
      if (m_rv != '0) begin
        check("model_value", 64'(value_out), 64'(vf(m_addr_prev)));
        check("model_indices", indices_out, xf(m_addr_prev));
      end
    end
    // advance the model to what the next clock edge produces
    if (reset) begin
      m_owner = N - 1;
      m_live  = 0;
      m_beats = 0;
      m_rv    = '0;
      m_init  = 1;
    end else begin
      m_rv        = exp_g;
      m_addr_prev = exp_addr;
      if (gidx >= 0) begin
        if (m_live && gidx == m_owner && m_beats < MB) begin
          m_beats++;
        end else begin
          m_owner = gidx;
          m_beats = 1;
          m_live  = 1;
        end
      end else begin
        m_live = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [N-1:0] prev_eg = '0;

  task automatic cyc(input logic rst, input logic [N-1:0] r, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1, input logic [N-1:0] eg, input string name);
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    reset       = rst;
    req         = r;
    req_address = {a1, a0};
    #1;
    ea = (eg == 2'b01) ? a0 : (eg == 2'b10) ? a1 : '0;
    check({name, "_grant"}, 64'(grant), 64'(eg));
    check({name, "_ram_en"}, 64'(ram_en), 64'(eg != '0));
    check({name, "_addr"}, 64'(ram_address), 64'(ea));
    check({name, "_rvalid"}, 64'(rvalid), 64'(prev_eg));
    $display("cycle %s: req=%b grant=%b rvalid=%b ram_address=%0d", name, r, grant, rvalid, ram_address);
    prev_eg = eg;
  endtask

  initial begin
    reset       = 1'b1;
    req         = '0;
    req_address = '0;

    // reset with both requesting
    cyc(1'b1, 2'b11, 14'd0, 14'd0, 2'b00, "reset");
    cyc(1'b1, 2'b11, 14'd0, 14'd0, 2'b00, "reset");

    // contention from release: 4 beats each, requester 0 first
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 2'b11, AW'(100 + i), AW'(200 + i),
          (((i / 4) % 2) == 1) ? 2'b10 : 2'b01, "contend");
    end

    cyc(1'b0, 2'b00, 14'd0, 14'd0, 2'b00, "gap0");

    // single requester streams past its burst limit
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'b01, AW'(5 + k), 14'd0, 2'b01, "single");
      if (k >= 1) check("single_data", 64'(value_out), 64'(vf(AW'(5 + k - 1))));
    end

    // early release: requester 0 drops req after 2 beats
    cyc(1'b0, 2'b00, 14'd0, 14'd0, 2'b00, "gap1");
    cyc(1'b0, 2'b01, 14'd20, 14'd0, 2'b01, "early_a");
    cyc(1'b0, 2'b11, 14'd21, 14'd30, 2'b01, "early_b");
    cyc(1'b0, 2'b10, 14'd0, 14'd31, 2'b10, "early_c");
    cyc(1'b0, 2'b10, 14'd0, 14'd32, 2'b10, "early_d");
    cyc(1'b0, 2'b10, 14'd0, 14'd33, 2'b10, "early_e");

    // idle gap then both request: resumes after owner 1
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'b00, 14'd0, 14'd0, 2'b00, "idle");
    cyc(1'b0, 2'b11, 14'd40, 14'd50, 2'b01, "resume");
    cyc(1'b0, 2'b11, 14'd41, 14'd51, 2'b01, "resume");

    // reset mid-operation
    cyc(1'b1, 2'b11, 14'd42, 14'd52, 2'b00, "midrst");
    cyc(1'b0, 2'b11, 14'd43, 14'd53, 2'b01, "after_rst");
    cyc(1'b0, 2'b11, 14'd44, 14'd54, 2'b01, "after_rst");

    cyc(1'b0, 2'b00, 14'd0, 14'd0, 2'b00, "drain");
    cyc(1'b0, 2'b00, 14'd0, 14'd0, 2'b00, "drain");
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
